// File: rtl/dog_diff_stream.sv
// Streaming Difference-of-Gaussian engine.
// Subtracts NUM_CH pairs of unsigned blurred pixels, flags high-contrast results,
// formats each difference to OUT_W bits (clamp or wrap) and tags frame position.
// The whole pipeline advances on a single enable, so a stalled output freezes
// every stage and the input at the same time.
module dog_diff_stream #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int OUT_W  = 9,
  parameter int LAT    = 2,
  parameter int COLS   = 640,
  parameter int ROWS   = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_a,
  input  logic [NUM_CH*DATA_W-1:0] in_b,
  input  logic                     sat_en,
  input  logic [DATA_W-1:0]        thresh,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*OUT_W-1:0]  out_diff,
  output logic [NUM_CH-1:0]        out_flag,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_eof
);

  localparam int RAW_W = DATA_W + 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  // Clamp limits of an OUT_W-bit signed value, expressed in the raw width.
  localparam logic signed [RAW_W-1:0] MAX_S = RAW_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RAW_W-1:0] MIN_S = ~MAX_S;

  // Everything a beat needs downstream, captured at acceptance.
  typedef struct packed {
    logic                    vld;
    logic                    sof;
    logic                    eol;
    logic                    eof;
    logic                    sat;
    logic [NUM_CH-1:0]       flag;
    logic [NUM_CH*RAW_W-1:0] raw;
  } beat_t;

  logic             en;
  logic             acc;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             at_eol;
  logic             at_last_row;
  beat_t            in_beat;
  beat_t            fin;

  assign en          = ~out_valid | out_ready;
  assign in_ready    = en;
  assign acc         = in_valid & en;
  assign at_eol      = (col == COL_LAST);
  assign at_last_row = (row == ROW_LAST);

  // Signed difference of two unsigned pixels, one bit wider than the inputs.
  function automatic logic [RAW_W-1:0] diff_of(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    diff_of = {1'b0, a} - {1'b0, b};
  endfunction

  // Magnitude of a raw difference; |raw| <= 2^DATA_W-1 so DATA_W bits suffice.
  function automatic logic [DATA_W-1:0] mag_of(input logic [RAW_W-1:0] r);
    logic [RAW_W-1:0] neg;
    neg    = -r;
    mag_of = r[RAW_W-1] ? neg[DATA_W-1:0] : r[DATA_W-1:0];
  endfunction

  // Narrow a raw difference to OUT_W bits: pass, clamp, or keep the low bits.
  function automatic logic [OUT_W-1:0] fmt(input logic [RAW_W-1:0] r,
                                           input logic sat);
    logic signed [RAW_W-1:0] s;
    s = $signed(r);
    if (OUT_W == RAW_W)       fmt = r[OUT_W-1:0];
    else if (sat && s > MAX_S) fmt = MAX_S[OUT_W-1:0];
    else if (sat && s < MIN_S) fmt = MIN_S[OUT_W-1:0];
    else                       fmt = r[OUT_W-1:0];
  endfunction

  // Frame position counters advance once per accepted beat and wrap at frame end.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (at_eol) begin
        col <= '0;
        row <= at_last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage-1 arithmetic and per-beat side information at the input.
  // NOTE: the struct gets a full default first so no path leaves a field
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    in_beat     = '0;
    in_beat.vld = acc;
    in_beat.sof = acc & (col == '0) & (row == '0);
    in_beat.eol = acc & at_eol;
    in_beat.eof = acc & at_eol & at_last_row;
    in_beat.sat = sat_en;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      in_beat.raw[ch*RAW_W +: RAW_W] =
        diff_of(in_a[ch*DATA_W +: DATA_W], in_b[ch*DATA_W +: DATA_W]);
      in_beat.flag[ch] = (mag_of(in_beat.raw[ch*RAW_W +: RAW_W]) >= thresh);
    end
  end

  // LAT-1 intermediate stages; with LAT=1 the output register takes the input directly.
  if (LAT == 1) begin : g_direct
    assign fin = in_beat;
  end else begin : g_pipe
    beat_t mid [LAT-1];

    // Shift register of in-flight beats, frozen while the output is stalled.
    // NOTE: the whole stage is cleared on reset (not just vld) so nothing from
    // a dropped frame can leak out; the stages are few flops, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LAT - 1; i++) mid[i] <= '0;
      end else if (en) begin
        mid[0] <= in_beat;
        for (int i = 1; i < LAT - 1; i++) mid[i] <= mid[i-1];
      end
    end

    assign fin = mid[LAT-2];
  end

  // Final stage: format differences and present the beat; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_diff  <= '0;
      out_flag  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (en) begin
      out_valid <= fin.vld;
      out_flag  <= fin.flag;
      out_sof   <= fin.sof;
      out_eol   <= fin.eol;
      out_eof   <= fin.eof;
      for (int ch = 0; ch < NUM_CH; ch++)
        out_diff[ch*OUT_W +: OUT_W] <= fmt(fin.raw[ch*RAW_W +: RAW_W], fin.sat);
    end
  end

endmodule

// File: doc/dog_diff_stream.md
Name: dog_diff_stream

Overview:
- Streaming, parametrised signed-difference engine for the SIFT Difference-of-Gaussian (DoG) stage.
- Takes NUM_CH pairs of unsigned blurred-pixel streams (adjacent Gaussian scales) and produces signed DoG values, with optional saturation to a narrower output width.
- Flags each DoG value whose magnitude meets a contrast threshold.
- Carries frame-position tags (sof/eol/eof) so the downstream keypoint extractor needs no counters of its own.
- Sits between the Gaussian blur bank and the keypoint detector; uses a valid/ready handshake with back-pressure.

Parameters:
- DATA_W, 8, unsigned input pixel width.
- NUM_CH, 2, parallel DoG channels (scale pairs) per beat.
- OUT_W, 9, output DoG width; legal range 2..DATA_W+1.
- LAT, 2, pipeline stages from accepted input to out_valid; minimum 1.
- COLS, 640, pixels per row.
- ROWS, 480, rows per frame.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  NUM_CH*DATA_W  minuend pixels (finer scale); ch0 in the LSBs.
- in_b  in  NUM_CH*DATA_W  subtrahend pixels (coarser scale).
- sat_en  in  1  1 = clamp to OUT_W range; 0 = two's-complement wrap (keep low OUT_W bits).
- thresh  in  DATA_W  contrast threshold, unsigned.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_diff  out  NUM_CH*OUT_W  signed DoG per channel; ch0 in the LSBs.
- out_flag  out  NUM_CH  |raw diff| >= thresh, per channel.
- out_sof  out  1  beat is pixel (0,0).
- out_eol  out  1  beat is the last column of a row.
- out_eof  out  1  beat is the last pixel of the frame.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; col and row counters 0; every output register 0 (out_valid=0, out_diff=0, out_flag=0, tags=0).
- in_ready is combinational from reset state onward.
- Handshake:
  - Global enable en = ~out_valid | out_ready; in_ready = en.
  - A beat is accepted when in_valid & in_ready.
  - Every stage shifts on en; a stage whose valid bit is 0 is a bubble.
  - out_* hold stable while out_valid & ~out_ready.
- Latency: exactly LAT cycles from acceptance to out_valid when not stalled. Throughput: 1 beat/cycle.
- Sampling: sat_en, thresh and the position tags are captured at acceptance and travel with the beat. Changing them mid-stream never affects beats already in flight.
- Arithmetic, stage 1:
  - raw = {1'b0,a} - {1'b0,b}, DATA_W+1 bits, signed.
  - mag = |raw|, DATA_W bits unsigned (max 2^DATA_W-1; no overflow).
  - flag = (mag >= thresh); thresh=0 sets every flag.
- Output formatting, final stage:
  - OUT_W == DATA_W+1: raw passes through, sat_en ignored.
  - Otherwise, sat_en=1 clamps raw to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Otherwise, sat_en=0 outputs raw[OUT_W-1:0].
  - flag is always computed from the unclamped raw value.
- Position counting, on each accepted beat:
  - sof = (col==0 & row==0); eol = (col==COLS-1); eof = eol & (row==ROWS-1).
  - col increments; at COLS-1 it wraps to 0 and row increments.
  - After eof, row and col return to 0, so the next accepted beat is sof.
- Stall during a bubble: when out_valid=0, en=1 regardless of out_ready, so the pipeline fills.
- Simultaneous output pop and input accept in the same cycle is legal; no beat is lost or duplicated.
- Reset mid-frame: all in-flight beats are dropped, counters return to 0, and the first beat after reset is tagged sof.

Test Plan:
- DATA_W=8, OUT_W=9, LAT=2, ch0 a=5 b=6, ch1 a=6 b=5, thresh=1 -> two cycles later out_valid=1, ch0 diff=9'h1FF (-1), ch1 diff=9'h001 (+1), out_flag=2'b11.
- OUT_W=8, ch0 a=255 b=0, ch1 a=0 b=255:
  - sat_en=1 -> diffs +127 / -128 (8'h7F / 8'h80), flags 11 with thresh=200.
  - sat_en=0 -> diffs 8'hFF / 8'h01.
- thresh=10, a=100 b=91 -> flag 0; a=100 b=90 -> flag 1; a=90 b=100 -> flag 1 with diff -10.
- COLS=4, ROWS=2, 8 back-to-back beats, then a 9th:
  - sof on beat 0; eol on beats 3 and 7; eof on beat 7 only.
  - Beat 8 carries sof again.
- Stream 6 beats with out_ready held 0 for 3 cycles mid-stream:
  - in_ready=0 during the stall; out_* stay constant.
  - All 6 beats emerge in order, none duplicated.
- Assert rst for 1 cycle after beat 3 of 5 with the pipeline full:
  - out_valid=0 the next cycle.
  - The next accepted beat emerges with out_sof=1.
